// File: rtl/byte_unpack_to_q_pkg.sv
// Shared constants and types for the fixed-point pixel pipeline.
// Every Q-domain stage uses q_pix_t so word widths stay consistent end to end.
package byte_unpack_to_q_pkg;
  localparam int Q_N    = 20;
  localparam int Q_FRAC = 11;
  localparam int PIX_W  = 8;

  typedef logic [Q_N-1:0] q_pix_t;
endpackage

// File: rtl/byte_unpack_to_q_if.sv
// Stream bundle for the byte unpacker: packed-pixel input side and Q-pixel output side.
// slave is the unpacker's view; master is the view of whatever drives and sinks it.
interface byte_unpack_to_q_if
  import byte_unpack_to_q_pkg::*;
#(
  parameter int N     = Q_N,
  parameter int BYTES = 4
);
  logic [PIX_W*BYTES-1:0] s_tdata;
  logic [BYTES-1:0]       s_tkeep;
  logic                   s_tlast;
  logic                   s_tvalid;
  logic                   s_tready;
  logic [N-1:0]           m_data;
  logic                   m_last;
  logic                   m_valid;
  logic                   m_ready;

  modport slave (
    input  s_tdata, s_tkeep, s_tlast, s_tvalid, m_ready,
    output s_tready, m_data, m_last, m_valid
  );

  modport master (
    output s_tdata, s_tkeep, s_tlast, s_tvalid, m_ready,
    input  s_tready, m_data, m_last, m_valid
  );
endinterface

// File: rtl/byte_unpack_to_q_int2q.sv
// Unsigned 8-bit integer to Q-format: integer bits land above Q fractional zeros, sign bit 0.
module byte_unpack_to_q_int2q
  import byte_unpack_to_q_pkg::*;
#(
  parameter int N = Q_N,
  parameter int Q = Q_FRAC
) (
  input  logic [PIX_W-1:0] i_int,
  output logic [N-1:0]     o_q
);
  assign o_q = N'({1'b0, i_int}) << Q;
endmodule

// File: rtl/byte_unpack_to_q.sv
// Serialises packed pixel beats one byte per cycle and converts each byte to Q format.
// A beat's final byte may hand over to the next beat in the same cycle, so there are no bubbles.
module byte_unpack_to_q
  import byte_unpack_to_q_pkg::*;
#(
  parameter int N     = Q_N,
  parameter int Q     = Q_FRAC,
  parameter int BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  byte_unpack_to_q_if.slave    io_if
);
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CW = $clog2(BYTES + 1);

  logic [PIX_W*BYTES-1:0] r_word;
  logic [CW-1:0]          r_cnt;
  logic                   r_last;
  logic                   r_full;
  logic [IW-1:0]          r_idx;

  logic [BYTES-1:0]       w_run;
  logic [CW-1:0]          w_keep_cnt;
  logic                   w_last_byte;
  logic                   w_xfer;
  logic                   w_accept;
  logic [PIX_W-1:0]       w_pix;

  // w_run is a thermometer of the leading contiguous keep bits; a hole ends the run.
  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_run
      assign w_run[gi] = &io_if.s_tkeep[gi:0];
    end
  endgenerate

  always_comb begin
    w_keep_cnt = '0;
    for (int i = 0; i < BYTES; i++) begin
      w_keep_cnt = w_keep_cnt + CW'(w_run[i]);
    end
  end

  // r_full guarantees r_cnt >= 1, so the decrement cannot wrap while it matters.
  assign w_last_byte = r_full && (CW'(r_idx) == (r_cnt - CW'(1)));
  assign w_xfer      = r_full && io_if.m_ready;
  assign w_accept    = io_if.s_tvalid && io_if.s_tready;
  assign w_pix       = r_word[PIX_W*r_idx +: PIX_W];

  assign io_if.s_tready = !r_full || (io_if.m_ready && w_last_byte);
  assign io_if.m_valid  = r_full;
  assign io_if.m_last   = r_full && r_last && w_last_byte;

  byte_unpack_to_q_int2q #(
    .N (N),
    .Q (Q)
  ) u_int2q (
    .i_int (w_pix),
    .o_q   (io_if.m_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_cnt  <= '0;
      r_last <= 1'b0;
      r_full <= 1'b0;
      r_idx  <= '0;
    end else if (w_xfer && !w_last_byte) begin
      r_idx <= r_idx + IW'(1);
    end else if (w_accept) begin
      r_word <= io_if.s_tdata;
      r_cnt  <= w_keep_cnt;
      r_last <= io_if.s_tlast;
      r_idx  <= '0;
      r_full <= (w_keep_cnt != '0);
    end else if (w_xfer) begin
      r_full <= 1'b0;
    end
  end
endmodule

// File: tb/tb_byte_unpack_to_q.sv
// Scoreboard bench for byte_unpack_to_q: accepted beats are expanded into expected pixels,
// and a negedge monitor compares every presented output against the queue head.
module tb_byte_unpack_to_q;
  localparam int N     = 20;
  localparam int BYTES = 4;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   rmode    = 0;
  exp_t exp_q[$];

  byte_unpack_to_q_if #(.N(N), .BYTES(BYTES)) bus();

  byte_unpack_to_q #(.N(N), .Q(11), .BYTES(BYTES)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_if (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: keep the leading run of kept bytes, each pixel is byte * 2^11.
  function automatic void model_push(input logic [31:0] d, input logic [3:0] k, input logic l);
    int c = 0;
    while (c < BYTES && k[c]) c++;
    for (int i = 0; i < c; i++) begin
      exp_t e;
      e.data = int'(d[8*i +: 8]) * 2048;
      e.last = l && (i == c - 1);
      exp_q.push_back(e);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       bus.m_ready = 1'b1;
      1:       bus.m_ready = ~bus.m_ready;
      default: bus.m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!rst && bus.m_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output got data=0x%0h last=%0b expected=none", bus.m_data, bus.m_last);
      end else begin
        check("m_data", int'(bus.m_data), exp_q[0].data);
        check("m_last", int'(bus.m_last), int'(exp_q[0].last));
        if (bus.m_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge with s_tvalid still high.
  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
    int   n   = 0;
    logic acc = 1'b0;
    bus.s_tdata  = d;
    bus.s_tkeep  = k;
    bus.s_tlast  = l;
    bus.s_tvalid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.s_tready;
      if (acc) model_push(d, k, l);
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=not_accepted expected=accepted data=0x%0h", d);
      bus.s_tvalid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    bus.s_tvalid = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || bus.m_valid) && n < 500);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_m_valid", int'(bus.m_valid), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.s_tdata  = '0;
    bus.s_tkeep  = '0;
    bus.s_tlast  = 1'b0;
    bus.s_tvalid = 1'b0;
    bus.m_ready  = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", int'(bus.m_valid), 0);
    check("rst_m_last", int'(bus.m_last), 0);
    check("rst_m_data", int'(bus.m_data), 0);
    check("rst_s_tready", int'(bus.s_tready), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single full beat with s_tready timing.
    bus.s_tdata = 32'h04030201; bus.s_tkeep = 4'hF; bus.s_tlast = 1'b1; bus.s_tvalid = 1'b1;
    @(negedge clk);
    check("t1_ready_idle", int'(bus.s_tready), 1);
    model_push(32'h04030201, 4'hF, 1'b1);
    @(posedge clk);
    #1;
    bus.s_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_m_valid", int'(bus.m_valid), 1);
      check("t1_s_tready", int'(bus.s_tready), (i == 3) ? 1 : 0);
    end
    drain();

    // Back-to-back beats: eight pixels with no gap.
    fork
      begin
        send(32'hFF000080, 4'hF, 1'b0);
        send(32'h00000001, 4'hF, 1'b1);
        bus.s_tvalid = 1'b0;
      end
      begin
        int w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (!bus.m_valid && w < 20);
        for (int i = 0; i < 8; i++) begin
          if (i > 0) @(negedge clk);
          check("b2b_m_valid", int'(bus.m_valid), 1);
          check("b2b_s_tready", int'(bus.s_tready), (i == 3 || i == 7) ? 1 : 0);
        end
        @(negedge clk);
        check("b2b_end_valid", int'(bus.m_valid), 0);
      end
    join
    drain();

    // Partial keeps, including a hole that drops higher bytes.
    send(32'hAABB1122, 4'h3, 1'b1);
    send(32'h11223344, 4'hD, 1'b1);
    drain();

    // Alternating backpressure.
    rmode = 1;
    send(32'h44332211, 4'hF, 1'b1);
    drain();
    rmode = 0;

    // Empty beat is swallowed.
    send(32'hDEADBEEF, 4'h0, 1'b1);
    bus.s_tvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("empty_no_valid", int'(bus.m_valid), 0);
    end
    @(posedge clk);
    #1;
    send(32'h0A0B0C0D, 4'hF, 1'b1);
    drain();

    // Asynchronous reset in the middle of a beat.
    send(32'h55667788, 4'hF, 1'b1);
    bus.s_tvalid = 1'b0;
    begin
      int w = 0;
      while (exp_q.size() > 2 && w < 50) begin
        @(posedge clk);
        w++;
      end
    end
    #2;
    rst = 1'b1;
    #1;
    check("arst_m_valid", int'(bus.m_valid), 0);
    check("arst_m_last", int'(bus.m_last), 0);
    exp_q.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_s_tready", int'(bus.s_tready), 1);
    check("arst_m_data", int'(bus.m_data), 0);
    @(posedge clk);
    #1;
    send(32'h9C9D9E9F, 4'hF, 1'b1);
    drain();

    // Randomised beats, keeps, gaps and backpressure.
    rmode = 2;
    for (int b = 0; b < 40; b++) begin
      logic [31:0] d;
      logic [3:0]  k;
      d = $urandom;
      k = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      send(d, k, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        bus.s_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    rmode = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/byte_unpack_to_q.md
Name: byte_unpack_to_q

Overview:
- Input stage of the fixed-point pipeline.
- Accepts packed 8-bit pixel words from the DMA stream (BYTES pixels per beat), serialises them one byte per cycle, and converts each byte to an unsigned-positive Q-format word.
- Feeds the downstream Q-domain arithmetic with a valid/ready handshake.
- Preserves frame boundaries (last) and sustains 1 pixel/cycle with no bubbles between beats.

Parameters:
N, 20, total fixed-point width (sign + 8 integer + fractional bits)
Q, 11, fractional bit count; N must equal Q+9
BYTES, 4, pixels packed per input beat

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
s_tdata  input  8*BYTES  packed pixels; byte 0 = bits [7:0], sent first
s_tkeep  input  BYTES  byte enables, LSB-first
s_tlast  input  1  final beat of frame
s_tvalid  input  1  input beat valid
s_tready  output  1  input beat accepted when s_tvalid && s_tready
m_data  output  N  Q-format pixel = {1'b0, byte, Q zeros}
m_last  output  1  final pixel of frame
m_valid  output  1  output valid
m_ready  input  1  downstream ready

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- State:
  - holding register: word, cnt (kept-byte count), last flag
  - full flag
  - byte index idx (0..BYTES-1)
- Reset: full=0, idx=0, word=0, cnt=0, last=0.
  - Outputs during reset: m_valid=0, m_last=0, m_data=0, s_tready=1.
- Reset mid-word: remaining bytes are discarded. No output follows until a new beat is accepted.
- cnt rule: number of contiguous 1s in s_tkeep starting at bit 0.
  - Bytes above the first 0 are dropped, even if their keep bit is set.
- Outputs:
  - m_valid = full.
  - m_data = conversion of word[8*idx +: 8], driven combinationally from registers only (no input-to-output combinational path).
  - m_last = full && last && (idx == cnt-1).
- s_tready = !full || (m_valid && m_ready && idx == cnt-1).
  - Combinational on m_ready only; no dependency on s_tvalid.
- Per-cycle update, in priority order:
  1. Output transfer (m_valid && m_ready) with idx < cnt-1: idx <= idx+1.
  2. Input accept (s_tvalid && s_tready): load word/cnt/last, idx <= 0, full <= (cnt != 0). This may coincide with the final-byte transfer, giving zero-bubble chaining.
  3. Final-byte transfer with no accept: full <= 0.
- Latency: beat accepted at edge k → byte 0 valid after edge k (cycle k+1).
- Throughput: steady state is 1 pixel/cycle. A beat of c kept bytes occupies c cycles.
- Backpressure: while m_valid && !m_ready, m_data/m_last/idx hold stable; s_tready=0 if full.
- cnt==0 beat: accepted and dropped with no output. Its tlast is also dropped (documented limitation; upstream never sends empty last beats).
- Width rule: output bit N-1 is always 0. No rounding or saturation needed; every 8-bit value is exactly representable.

Decomposition:
- Shared package:
  - Q_N=20, Q_FRAC=11 constants
  - PIX_W=8
  - a typedef for the Q pixel word, reused by all Q-domain stages
- Sub-module: the existing int-to-Q conversion module, instantiated once on the selected byte with N/Q passed through.
- Byte select and keep-count logic stay inline.

Test Plan:
- Reset, then one beat s_tdata=0x04030201, keep=0xF, last=1, m_ready=1 → m_data = 0x00800, 0x01000, 0x01800, 0x02000 on 4 consecutive cycles; m_last only on the 4th; s_tready low cycles 1–3.
- Back-to-back beats 0xFF000080 then 0x00000001, both keep=0xF, s_tvalid held high → 8 outputs with no gap; 0xFF → 0x7F800; s_tready pulses high on each final byte.
- Beat with keep=0x3 (0xAABB1122), last=1 → exactly 2 outputs (0x22, 0x11 converted); m_last on the 2nd. keep=0xD → 1 output only.
- m_ready toggling 1010… during a beat → each byte emitted exactly once in order; m_data stable while stalled.
- Beat with keep=0x0 → accepted, no m_valid; the following full beat is output normally.
- rst asserted asynchronously mid-beat (after byte 1) → m_valid drops immediately; next beat starts at byte 0.
